// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg
//   Shared definitions for the logic unit: 3-bit op encodings, FSM state
//   encodings and a single-bit helper that evaluates one bitwise op.
//   Optional feature macro used by the top: LOGIC_UNIT_PARITY_EN.
package logic_unit_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_XNOR = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;
  localparam logic [2:0] OP_NOTA = 3'd6;
  localparam logic [2:0] OP_XACC = 3'd7;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } state_t;

  // One bit of f(op,a,b). XACC is not a per-beat result, so it yields 0 here;
  // the accumulator path in the top supplies the XACC value.
  function automatic logic op_bit(input logic [2:0] op, input logic a, input logic b);
    logic r;
    r = 1'b0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_XNOR: r = ~(a ^ b);
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_NOTA: r = ~a;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_op_comb.sv
// logic_op_comb
//   Purely combinational bitwise function y = f(op, a, b) for ops 0-6.
//   Ports:
//     op  in  3      op select (encodings from logic_unit_pkg)
//     a   in  WIDTH  operand A
//     b   in  WIDTH  operand B (unused by NOT A)
//     y   out WIDTH  result
module logic_op_comb
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign y[gi] = op_bit(op, a[gi], b[gi]);
    end
  endgenerate

endmodule

// File: rtl/logic_unit.sv
// logic_unit
//   Registered bitwise logic unit with valid/ready on both sides and a
//   1-cycle latency. Ops 0-6 produce one result per beat; op 7 (XACC)
//   XOR-folds a multi-beat packet into a single result word.
//   Optional: define LOGIC_UNIT_PARITY_EN to add the out_parity port.
//   Ports:
//     clk        in   1      clock, rising edge
//     reset      in   1      synchronous, active-high
//     in_valid   in   1      operand beat present
//     in_ready   out  1      beat can be accepted this cycle
//     in_a/in_b  in   WIDTH  operands
//     in_op      in   3      op select
//     in_last    in   1      last beat of an XACC packet
//     out_valid  out  1      result register valid
//     out_ready  in   1      downstream takes result
//     out_y      out  WIDTH  result
//     out_beats  out  CNT_W  beats folded into out_y
//     out_parity out  1      ^out_y (LOGIC_UNIT_PARITY_EN only)
module logic_unit
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [CNT_W-1:0] out_beats
`ifdef LOGIC_UNIT_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             out_valid_reg, out_valid_next;
  logic [WIDTH-1:0] out_y_reg, out_y_next;
  logic [CNT_W-1:0] out_beats_reg, out_beats_next;

  logic [WIDTH-1:0] op_y;
  logic [WIDTH-1:0] acc_fold;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;
  logic             is_xacc;
  logic             load_result;

  logic_op_comb #(.WIDTH(WIDTH)) u_op (
    .op (in_op),
    .a  (in_a),
    .b  (in_b),
    .y  (op_y)
  );

  assign in_ready = !out_valid_reg || out_ready;
  assign accept   = in_valid && in_ready;
  assign is_xacc  = (in_op == OP_XACC);
  assign acc_fold = acc_reg ^ in_a ^ in_b;
  // Beat counter sticks at all-ones; the accumulator keeps folding regardless.
  assign cnt_inc  = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + CNT_W'(1);
  // A result is produced by every non-XACC beat and by the closing XACC beat.
  assign load_result = accept && (!is_xacc || in_last);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_y_reg     <= '0;
      out_beats_reg <= '0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      cnt_reg       <= cnt_next;
      out_valid_reg <= out_valid_next;
      out_y_reg     <= out_y_next;
      out_beats_reg <= out_beats_next;
    end
  end

  // Next-state logic: only XACC beats move the packet FSM.
  always_comb begin
    state_next = state_reg;
    if (accept && is_xacc) begin
      state_next = in_last ? S_IDLE : S_ACC;
    end
  end

  // Datapath / output logic
  always_comb begin
    acc_next       = acc_reg;
    cnt_next       = cnt_reg;
    out_valid_next = out_valid_reg;
    out_y_next     = out_y_reg;
    out_beats_next = out_beats_reg;

    if (out_valid_reg && out_ready) begin
      out_valid_next = 1'b0;
    end

    if (accept && is_xacc) begin
      if (in_last) begin
        acc_next = '0;
        cnt_next = '0;
      end else begin
        acc_next = acc_fold;
        cnt_next = cnt_inc;
      end
    end

    if (load_result) begin
      out_valid_next = 1'b1;
      out_y_next     = is_xacc ? acc_fold : op_y;
      out_beats_next = is_xacc ? cnt_inc : CNT_W'(1);
    end
  end

  assign out_valid = out_valid_reg;
  assign out_y     = out_y_reg;
  assign out_beats = out_beats_reg;

`ifdef LOGIC_UNIT_PARITY_EN
  logic out_parity_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_parity_reg <= 1'b0;
    end else if (load_result) begin
      out_parity_reg <= ^out_y_next;
    end
  end

  assign out_parity = out_parity_reg;
`endif

endmodule

// File: tb/tb_logic_unit.sv
module tb_logic_unit;
  import logic_unit_pkg::*;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [2:0] in_op;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_y;
  logic [7:0] out_beats;
`ifdef LOGIC_UNIT_PARITY_EN
  logic       out_parity;
`endif

  int checks;
  int failures;

  logic_unit #(.WIDTH(8), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_beats (out_beats)
`ifdef LOGIC_UNIT_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one beat at the current negedge; return at the next negedge,
  // after the rising edge that accepts it.
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic last);
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    in_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_y !== 8'h00 || out_beats !== 8'h00) begin
      failures++;
      $display("FAIL reset_state: valid=%b y=%h beats=%0d, required valid=0 y=00 beats=0",
               out_valid, out_y, out_beats);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
`ifdef LOGIC_UNIT_PARITY_EN
    checks++;
    if (out_parity !== 1'b0) begin
      failures++;
      $display("FAIL reset_parity: got %b, required 0", out_parity);
    end
`endif
    reset = 1'b0;
    $display("reset: valid=%b y=%h beats=%0d", out_valid, out_y, out_beats);
  endtask

  task automatic test_ops();
    logic [7:0] exp_y [7];
    exp_y = '{8'h05, 8'hAF, 8'hAA, 8'h55, 8'hFA, 8'h50, 8'h5A};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL ops_in_ready op=%0d: got %b, required 1", i, in_ready);
      end
      send(3'(i), 8'hA5, 8'h0F, 1'b0);
      $display("op=%0d a=a5 b=0f -> y=%h beats=%0d", i, out_y, out_beats);
      checks++;
      if (out_valid !== 1'b1 || out_y !== exp_y[i] || out_beats !== 8'd1) begin
        failures++;
        $display("FAIL op_%0d: valid=%b y=%h beats=%0d, required valid=1 y=%h beats=1",
                 i, out_valid, out_y, out_beats, exp_y[i]);
      end
`ifdef LOGIC_UNIT_PARITY_EN
      checks++;
      if (out_parity !== ^exp_y[i]) begin
        failures++;
        $display("FAIL parity_op_%0d: got %b, required %b", i, out_parity, ^exp_y[i]);
      end
`endif
    end
    idle();
    checks++;
    if (out_valid !== 1'b0 || out_y !== 8'h5A) begin
      failures++;
      $display("FAIL ops_drain: valid=%b y=%h, required valid=0 y=5a", out_valid, out_y);
    end
  endtask

  task automatic test_xacc();
    out_ready = 1'b1;
    send(OP_XACC, 8'h01, 8'h02, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL xacc_beat1_no_output: valid=%b, required 0", out_valid);
    end
    send(OP_XACC, 8'h04, 8'h08, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL xacc_beat2_no_output: valid=%b, required 0", out_valid);
    end
    send(OP_XACC, 8'h10, 8'h00, 1'b1);
    $display("xacc packet: y=%h beats=%0d", out_y, out_beats);
    checks++;
    if (out_valid !== 1'b1 || out_y !== 8'h1F || out_beats !== 8'd3) begin
      failures++;
      $display("FAIL xacc_result: valid=%b y=%h beats=%0d, required valid=1 y=1f beats=3",
               out_valid, out_y, out_beats);
    end
    idle();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(OP_AND, 8'hA5, 8'h0F, 1'b0);
    // A non-last XACC beat waits on the input while the output is stalled.
    in_op    = OP_XACC;
    in_a     = 8'hFF;
    in_b     = 8'h00;
    in_last  = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_y !== 8'h05 || out_beats !== 8'd1) begin
        failures++;
        $display("FAIL stall_cycle_%0d: in_ready=%b valid=%b y=%h beats=%0d, required 0 1 05 1",
                 i, in_ready, out_valid, out_y, out_beats);
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_release_ready: got %b, required 1", in_ready);
    end
    @(negedge clk);
    $display("stall release: valid=%b y=%h", out_valid, out_y);
    checks++;
    if (out_valid !== 1'b0 || out_y !== 8'h05) begin
      failures++;
      $display("FAIL stall_drain: valid=%b y=%h, required valid=0 y=05", out_valid, out_y);
    end
    // The stalled XACC beat must not have been folded in.
    send(OP_XACC, 8'h11, 8'h00, 1'b1);
    checks++;
    if (out_y !== 8'h11 || out_beats !== 8'd1) begin
      failures++;
      $display("FAIL stall_no_fold: y=%h beats=%0d, required y=11 beats=1", out_y, out_beats);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [7:0] va [5];
    logic [7:0] ve [5];
    va = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    ve = '{8'h3C, 8'h2D, 8'h1E, 8'h0F, 8'h78};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_ready_%0d: got %b, required 1", i, in_ready);
      end
      send(OP_XOR, va[i], 8'h3C, 1'b0);
      $display("b2b xor a=%h b=3c -> y=%h", va[i], out_y);
      checks++;
      if (out_valid !== 1'b1 || out_y !== ve[i]) begin
        failures++;
        $display("FAIL b2b_%0d: valid=%b y=%h, required valid=1 y=%h", i, out_valid, out_y, ve[i]);
      end
    end
    idle();
  endtask

  task automatic test_interleave();
    out_ready = 1'b1;
    send(OP_XACC, 8'hF0, 8'h00, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL ilv_first_no_output: valid=%b, required 0", out_valid);
    end
    send(OP_AND, 8'hFF, 8'h0C, 1'b0);
    $display("interleave and: y=%h beats=%0d", out_y, out_beats);
    checks++;
    if (out_valid !== 1'b1 || out_y !== 8'h0C || out_beats !== 8'd1) begin
      failures++;
      $display("FAIL ilv_and: valid=%b y=%h beats=%0d, required valid=1 y=0c beats=1",
               out_valid, out_y, out_beats);
    end
    send(OP_XACC, 8'h0F, 8'h00, 1'b1);
    $display("interleave xacc: y=%h beats=%0d", out_y, out_beats);
    checks++;
    if (out_valid !== 1'b1 || out_y !== 8'hFF || out_beats !== 8'd2) begin
      failures++;
      $display("FAIL ilv_xacc: valid=%b y=%h beats=%0d, required valid=1 y=ff beats=2",
               out_valid, out_y, out_beats);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    send(OP_XACC, 8'h01, 8'h00, 1'b0);
    send(OP_XACC, 8'h02, 8'h00, 1'b0);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_y !== 8'h00 || out_beats !== 8'h00) begin
      failures++;
      $display("FAIL mid_reset_state: valid=%b y=%h beats=%0d, required 0 00 0",
               out_valid, out_y, out_beats);
    end
    reset = 1'b0;
    send(OP_XACC, 8'h33, 8'h00, 1'b1);
    $display("after mid reset: y=%h beats=%0d", out_y, out_beats);
    checks++;
    if (out_valid !== 1'b1 || out_y !== 8'h33 || out_beats !== 8'd1) begin
      failures++;
      $display("FAIL mid_reset_packet: valid=%b y=%h beats=%0d, required valid=1 y=33 beats=1",
               out_valid, out_y, out_beats);
    end
    idle();
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    for (int i = 0; i < 259; i++) begin
      send(OP_XACC, 8'h01, 8'h00, 1'b0);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL sat_no_output: valid=%b, required 0", out_valid);
    end
    send(OP_XACC, 8'h01, 8'h00, 1'b1);
    $display("saturation packet (260 beats): y=%h beats=%0d", out_y, out_beats);
    checks++;
    if (out_valid !== 1'b1 || out_y !== 8'h00 || out_beats !== 8'd255) begin
      failures++;
      $display("FAIL sat_result: valid=%b y=%h beats=%0d, required valid=1 y=00 beats=255",
               out_valid, out_y, out_beats);
    end
    idle();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = 8'h00;
    in_b      = 8'h00;
    in_op     = OP_AND;
    in_last   = 1'b0;
    out_ready = 1'b0;

    test_reset();
    test_ops();
    test_xacc();
    test_backpressure();
    test_back_to_back();
    test_interleave();
    test_reset_mid();
    test_saturation();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
